clkspec_ncr_acc_frame: RTL
==========================

// Module: clkspec_ncr_acc_frame
// PURPOSE
//  Downstream consumer of the 2-way interleaved NCR 8x8 multiplier. Accumulates a frame of
//  FRAME_LEN unsigned products into one sum and hands finished sums to the next stage.
//  Finished sums wait in a 2-entry result buffer behind a valid/ready handshake.
//  Intake stalls only when that buffer is full.
// PARAMETERS
//  WIDTH  8   multiplier operand width; product bus is 2*WIDTH bits
//  LEN_W  8   frame-length field width
//  ACC_W  20  accumulator/result width; must be >= 2*WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state
//  prod_vld   in   1        product on prod is valid this cycle
//  prod       in   2*WIDTH  unsigned product from the multiplier stage
//  prod_rdy   out  1        block accepts prod this cycle
//  frame_len  in   LEN_W    products per frame; 0 means 2**LEN_W
//  res_vld    out  1        result buffer head is valid
//  res        out  ACC_W    frame sum at buffer head
//  res_ovf    out  1        frame at head exceeded ACC_W bits
//  res_rdy    in   1        consumer takes head this cycle
//  busy       out  1        a frame is partially accumulated
// BEHAVIOUR
//  - Reset values: prod_rdy=1, res_vld=0, res=0, res_ovf=0, busy=0; acc, cnt, buffer cleared.
//  - Accept = prod_vld & prod_rdy.
//  - prod_rdy = (buf_count < 2), registered-state only; no combinational path from res_rdy.
//  - FSM IDLE/ACC:
//    - IDLE + accept: latch len_q = frame_len (0 -> 2**LEN_W); acc = prod; cnt = 1.
//      Go to ACC, or complete immediately if len_q == 1.
//    - ACC + accept: acc = acc + prod; cnt++. When cnt reaches len_q, complete -> IDLE.
//    - frame_len changes during ACC are ignored until the next IDLE accept.
//  - Complete: push {ovf_frame, sum} into the buffer on the same edge that takes the last
//    product. res_vld rises the cycle after the last accepted product (latency 1).
//  - Arithmetic: unsigned. ovf_frame is set by any carry out of bit ACC_W-1 within the frame
//    and cleared at frame start. Without the optional feature, the sum wraps modulo 2**ACC_W.
//  - Buffer: 2-entry FIFO, in-order; head drives res/res_ovf.
//    - Pop = res_vld & res_rdy.
//    - Push and pop in the same cycle: count unchanged, data ordered correctly.
//    - Full (count 2): prod_rdy=0; a pop this cycle raises prod_rdy next cycle.
//    - res/res_ovf hold stable while res_vld & !res_rdy.
//  - Reset mid-frame: partial sum discarded and buffer flushed; no res_vld after release.
//  - busy = (state == ACC).
// CONFIGURATION
//  CLKSPEC_ACC_SAT_EN defined: on overflow the acc clamps to 2**ACC_W-1 and stays there for
//  the rest of the frame; res_ovf is still set.
//  Not defined: wrap-around as above; res_ovf flags it.
// STRUCTURE
//  - Shared include clkspec_defs.vh holds:
//    - FSM state encodings (`CLKSPEC_ACC_IDLE 1'b0, `CLKSPEC_ACC_ACC 1'b1);
//    - default WIDTH/LEN_W/ACC_W values, shared with the multiplier stage.
//  - One sub-module, clkspec_acc_resbuf: 2-entry FIFO
//    (push/pop/full/empty, data width ACC_W+1).
//  - FSM, counter and adder stay in the top module.
// TESTING
//  1 len=4; prod 1,2,3,4 back-to-back, res_rdy=1 -> one result, res=10, res_ovf=0,
//    res_vld high exactly 1 cycle after 4th accept.
//  2 res_rdy=0; three len=1 frames with prod 5,6,7 -> prod_rdy drops after 2nd accept.
//    Raise res_rdy -> results 5,6,7 in order; prod_rdy returns 1 cycle after first pop.
//  3 len=17; every prod=0xFE01 -> res=0x0DE11, res_ovf=1 (0xFFFFF with CLKSPEC_ACC_SAT_EN).
//  4 frame_len=0; 256 products of value 1 -> res=0x00100, busy high until the 256th accept.
//  5 len=4; assert reset after 2 accepts -> all outputs at reset values; next len=2 frame
//    of 3,4 -> res=7.
//  6 frame_len changed 4->2 mid-frame, and push with simultaneous pop at count=1
//    -> frame still takes 4 products; buffer count stays 1 and output order is preserved.

Source files
------------

// File: rtl/clkspec_ncr_acc_frame_pkg.sv
// Shared definitions for the NCR accumulator frame stage.
// Holds the FSM state encodings and the default operand/length/accumulator widths.
`ifndef CLKSPEC_ACC_IDLE
`define CLKSPEC_ACC_IDLE 1'b0
`endif
`ifndef CLKSPEC_ACC_ACC
`define CLKSPEC_ACC_ACC 1'b1
`endif

package clkspec_ncr_acc_frame_pkg;

  localparam int CLKSPEC_WIDTH = 8;
  localparam int CLKSPEC_LEN_W = 8;
  localparam int CLKSPEC_ACC_W = 20;

  typedef enum logic {
    ACC_IDLE = `CLKSPEC_ACC_IDLE,
    ACC_ACC  = `CLKSPEC_ACC_ACC
  } acc_state_e;

endpackage

// File: rtl/clkspec_acc_resbuf.sv
// Two-entry in-order result buffer between the accumulator and the consumer.
// Push on a full buffer and pop on an empty one are ignored.
module clkspec_acc_resbuf #(
  parameter int DW = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push & (count_r != 2'd2);
  assign do_pop_s  = pop & (count_r != 2'd0);

  // Storage, pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/clkspec_ncr_acc_frame.sv
// Frame accumulator behind the interleaved NCR multiplier: sums frame_len products per frame.
// Optional macro CLKSPEC_ACC_SAT_EN makes the sum saturate instead of wrapping on overflow.
module clkspec_ncr_acc_frame
  import clkspec_ncr_acc_frame_pkg::*;
#(
  parameter int WIDTH = CLKSPEC_WIDTH,
  parameter int LEN_W = CLKSPEC_LEN_W,
  parameter int ACC_W = CLKSPEC_ACC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prod_vld,
  input  logic [2*WIDTH-1:0] prod,
  output logic               prod_rdy,
  input  logic [LEN_W-1:0]   frame_len,
  output logic               res_vld,
  output logic [ACC_W-1:0]   res,
  output logic               res_ovf,
  input  logic               res_rdy,
  output logic               busy
);

  acc_state_e       state_r;
  acc_state_e       state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic [LEN_W:0]   cnt_r;
  logic [LEN_W:0]   cnt_nxt_s;
  logic [LEN_W:0]   len_r;
  logic [LEN_W:0]   len_nxt_s;
  logic [LEN_W:0]   len_in_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             accept_s;
  logic             last_s;
  logic             busy_s;
  logic             buf_full_s;
  logic             buf_empty_s;
  logic [ACC_W:0]   buf_dout_s;

  assign accept_s   = prod_vld & prod_rdy;
  assign prod_ext_s = ACC_W'(prod);
  assign sum_s      = {1'b0, acc_r} + {1'b0, prod_ext_s};
  // A zero length field stands for the largest frame, 2**LEN_W products.
  assign len_in_s   = (frame_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, frame_len};

  // Accumulator, overflow flag, product counter and latched frame length.
  always_comb begin
    acc_nxt_s = acc_r;
    ovf_nxt_s = ovf_r;
    cnt_nxt_s = cnt_r;
    len_nxt_s = len_r;
    last_s    = 1'b0;
    if (accept_s) begin
      if (state_r == ACC_IDLE) begin
        acc_nxt_s = prod_ext_s;
        ovf_nxt_s = 1'b0;
        cnt_nxt_s = (LEN_W+1)'(1);
        len_nxt_s = len_in_s;
        last_s    = (len_in_s == (LEN_W+1)'(1));
      end else begin
        ovf_nxt_s = ovf_r | sum_s[ACC_W];
`ifdef CLKSPEC_ACC_SAT_EN
        if (ovf_r | sum_s[ACC_W]) begin
          acc_nxt_s = {ACC_W{1'b1}};
        end else begin
          acc_nxt_s = sum_s[ACC_W-1:0];
        end
`else
        acc_nxt_s = sum_s[ACC_W-1:0];
`endif
        cnt_nxt_s = cnt_r + (LEN_W+1)'(1);
        last_s    = ((cnt_r + (LEN_W+1)'(1)) == len_r);
      end
    end else begin
      last_s = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
      cnt_r <= '0;
      len_r <= '0;
    end else begin
      acc_r <= acc_nxt_s;
      ovf_r <= ovf_nxt_s;
      cnt_r <= cnt_nxt_s;
      len_r <= len_nxt_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ACC_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a one-product frame completes without leaving IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACC_IDLE: begin
        if (accept_s && !last_s) state_nxt_s = ACC_ACC;
        else                     state_nxt_s = ACC_IDLE;
      end
      ACC_ACC: begin
        if (accept_s && last_s) state_nxt_s = ACC_IDLE;
        else                    state_nxt_s = ACC_ACC;
      end
      default: state_nxt_s = ACC_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ACC_IDLE: busy_s = 1'b0;
      ACC_ACC:  busy_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  assign busy = busy_s;

  clkspec_acc_resbuf #(
    .DW(ACC_W + 1)
  ) u_resbuf (
    .clk   (clk),
    .reset (reset),
    .push  (last_s),
    .pop   (res_vld & res_rdy),
    .din   ({ovf_nxt_s, acc_nxt_s}),
    .dout  (buf_dout_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  assign prod_rdy = ~buf_full_s;
  assign res_vld  = ~buf_empty_s;
  assign res      = buf_dout_s[ACC_W-1:0];
  assign res_ovf  = buf_dout_s[ACC_W];

endmodule
